// File: rtl/input_loader_mmap_m_axi_read_throttle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_loader_mmap_m_axi_read_throttle_pkg
// Purpose  : Width helpers shared by the read-throttle block and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package input_loader_mmap_m_axi_read_throttle_pkg;

    // Burst-length credit compares run at this width so ARLEN+1 = 256 fits.
    localparam int ARLEN_CMP_WIDTH = 9;

    // Ceiling log2; loop bound keeps the shift inside a positive int.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counters able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return log2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_loader_mmap_m_axi_read_throttle_fifo.sv
`default_nettype none
// ============================================================================
// Module   : input_loader_mmap_m_axi_fifo
// Purpose  : Show-ahead synchronous FIFO with clock enable (m_axi family).
// Revision : 1.0 - initial release
// ============================================================================
module input_loader_mmap_m_axi_fifo
    import input_loader_mmap_m_axi_read_throttle_pkg::*;
#(
    parameter int DATA_BITS = 33,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    output logic                 if_full_n,
    input  logic                 if_write,
    input  logic [DATA_BITS-1:0] if_din,
    output logic                 if_empty_n,
    input  logic                 if_read,
    output logic [DATA_BITS-1:0] if_dout
);

    localparam int AW = log2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 w_push;
    logic                 w_pop;

    assign if_full_n  = (r_count != c_DEPTH);
    assign if_empty_n = (r_count != '0);
    assign w_push     = clk_en & if_write & if_full_n;
    assign w_pop      = clk_en & if_read  & if_empty_n;
    // Head entry is presented directly, so data is valid the cycle after write.
    assign if_dout    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_loader_mmap_m_axi_read_throttle.sv
`default_nettype none
// ============================================================================
// Module   : input_loader_mmap_m_axi_read_throttle
// Purpose  : Issues AR bursts only when buffer space is reserved for all beats.
// Revision : 1.0 - initial release
// ============================================================================
module input_loader_mmap_m_axi_read_throttle
    import input_loader_mmap_m_axi_read_throttle_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int MAXREQS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] in_TOP_ARADDR,
    input  logic [7:0]            in_TOP_ARLEN,
    input  logic                  in_TOP_ARVALID,
    output logic                  out_TOP_ARREADY,
    output logic [DATA_WIDTH-1:0] out_TOP_RDATA,
    output logic                  out_TOP_RLAST,
    output logic                  out_TOP_RVALID,
    input  logic                  in_TOP_RREADY,
    output logic [ADDR_WIDTH-1:0] out_BUS_ARADDR,
    output logic [7:0]            out_BUS_ARLEN,
    output logic                  out_BUS_ARVALID,
    input  logic                  in_BUS_ARREADY,
    input  logic [DATA_WIDTH-1:0] in_BUS_RDATA,
    input  logic                  in_BUS_RLAST,
    input  logic                  in_BUS_RVALID,
    output logic                  out_BUS_RREADY
);

    localparam int CW = cnt_width(DEPTH);
    localparam int OW = log2(MAXREQS + 1);
    localparam int NW = ARLEN_CMP_WIDTH;
    localparam logic [CW-1:0] c_DEPTH   = CW'(DEPTH);
    localparam logic [OW-1:0] c_MAXREQS = OW'(MAXREQS);

    logic [CW-1:0]         r_free_cnt;
    logic [OW-1:0]         r_out_cnt;
    logic [NW-1:0]         w_need;
    logic [NW-1:0]         w_free_ext;
    logic [NW-1:0]         w_dec;
    logic [NW-1:0]         w_inc;
    logic                  w_ar_en;
    logic                  w_ar_hs;
    logic                  w_top_pop;
    logic                  w_bus_beat;
    logic                  w_last_beat;
    logic                  w_fifo_full_n;
    logic                  w_fifo_empty_n;
    logic [DATA_WIDTH:0]   w_fifo_dout;

    assign out_BUS_ARADDR = in_TOP_ARADDR;
    assign out_BUS_ARLEN  = in_TOP_ARLEN;

    assign w_need     = {1'b0, in_TOP_ARLEN} + NW'(1);
    assign w_free_ext = {{(NW-CW){1'b0}}, r_free_cnt};

    // Issue gate uses only registered credit; same-cycle pops help next cycle.
    assign w_ar_en = clk_en & ~reset & (w_free_ext >= w_need) & (r_out_cnt < c_MAXREQS);

    assign out_BUS_ARVALID = in_TOP_ARVALID & w_ar_en;
    assign out_TOP_ARREADY = in_BUS_ARREADY & w_ar_en;
    assign w_ar_hs         = in_TOP_ARVALID & in_BUS_ARREADY & w_ar_en;

    assign out_BUS_RREADY = clk_en & ~reset & w_fifo_full_n;
    assign w_bus_beat     = in_BUS_RVALID & out_BUS_RREADY;
    assign w_last_beat    = w_bus_beat & in_BUS_RLAST;

    assign out_TOP_RVALID = w_fifo_empty_n;
    assign out_TOP_RLAST  = w_fifo_dout[DATA_WIDTH];
    assign out_TOP_RDATA  = w_fifo_dout[DATA_WIDTH-1:0];
    assign w_top_pop      = out_TOP_RVALID & in_TOP_RREADY & clk_en;

    assign w_dec = w_ar_hs   ? w_need : '0;
    assign w_inc = w_top_pop ? NW'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_free_cnt <= c_DEPTH;
            r_out_cnt  <= '0;
        end else begin
            r_free_cnt <= CW'(w_free_ext - w_dec + w_inc);
            case ({w_ar_hs, w_last_beat})
                2'b10:   r_out_cnt <= r_out_cnt + OW'(1);
                2'b01:   r_out_cnt <= r_out_cnt - OW'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    input_loader_mmap_m_axi_fifo #(
        .DATA_BITS (DATA_WIDTH + 1),
        .DEPTH     (DEPTH)
    ) u_rdata_fifo (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .if_full_n  (w_fifo_full_n),
        .if_write   (w_bus_beat),
        .if_din     ({in_BUS_RLAST, in_BUS_RDATA}),
        .if_empty_n (w_fifo_empty_n),
        .if_read    (in_TOP_RREADY),
        .if_dout    (w_fifo_dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_input_loader_mmap_m_axi_read_throttle.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_loader_mmap_m_axi_read_throttle
// Purpose  : Scoreboard bench for the read throttle (DEPTH=16, MAXREQS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_loader_mmap_m_axi_read_throttle;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_en = 1'b1;
    logic [AW-1:0] in_TOP_ARADDR = '0;
    logic [7:0]    in_TOP_ARLEN = '0;
    logic          in_TOP_ARVALID = 1'b0;
    logic          out_TOP_ARREADY;
    logic [DW-1:0] out_TOP_RDATA;
    logic          out_TOP_RLAST;
    logic          out_TOP_RVALID;
    logic          in_TOP_RREADY = 1'b0;
    logic [AW-1:0] out_BUS_ARADDR;
    logic [7:0]    out_BUS_ARLEN;
    logic          out_BUS_ARVALID;
    logic          in_BUS_ARREADY = 1'b0;
    logic [DW-1:0] in_BUS_RDATA = '0;
    logic          in_BUS_RLAST = 1'b0;
    logic          in_BUS_RVALID = 1'b0;
    logic          out_BUS_RREADY;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW:0]   sb[$];
    logic [DW:0]   exp_beat;
    logic [DW-1:0] seq = 32'hA000_0000;

    input_loader_mmap_m_axi_read_throttle #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (16),
        .MAXREQS    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .in_TOP_ARADDR   (in_TOP_ARADDR),
        .in_TOP_ARLEN    (in_TOP_ARLEN),
        .in_TOP_ARVALID  (in_TOP_ARVALID),
        .out_TOP_ARREADY (out_TOP_ARREADY),
        .out_TOP_RDATA   (out_TOP_RDATA),
        .out_TOP_RLAST   (out_TOP_RLAST),
        .out_TOP_RVALID  (out_TOP_RVALID),
        .in_TOP_RREADY   (in_TOP_RREADY),
        .out_BUS_ARADDR  (out_BUS_ARADDR),
        .out_BUS_ARLEN   (out_BUS_ARLEN),
        .out_BUS_ARVALID (out_BUS_ARVALID),
        .in_BUS_ARREADY  (in_BUS_ARREADY),
        .in_BUS_RDATA    (in_BUS_RDATA),
        .in_BUS_RLAST    (in_BUS_RLAST),
        .in_BUS_RVALID   (in_BUS_RVALID),
        .out_BUS_RREADY  (out_BUS_RREADY)
    );

    always #5 clk = ~clk;

    // Inputs only change at falling edges; this samples the settled handshake.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_TOP_RVALID && in_TOP_RREADY && clk_en) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL r_beat_unexpected: got %h, expected no beat", {out_TOP_RLAST, out_TOP_RDATA});
                end else begin
                    exp_beat = sb.pop_front();
                    if ({out_TOP_RLAST, out_TOP_RDATA} !== exp_beat) begin
                        n_fail++;
                        $display("FAIL r_beat: got %h, expected %h", {out_TOP_RLAST, out_TOP_RDATA}, exp_beat);
                    end
                end
            end
            if (in_BUS_RVALID && out_BUS_RREADY) begin
                sb.push_back({in_BUS_RLAST, in_BUS_RDATA});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_beat(input logic last);
        in_BUS_RVALID = 1'b1;
        in_BUS_RDATA  = seq;
        in_BUS_RLAST  = last;
        seq           = seq + 32'd1;
    endtask

    task automatic idle_bus();
        in_BUS_RVALID = 1'b0;
        in_BUS_RLAST  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_TOP_ARVALID = 1'b1; in_BUS_ARREADY = 1'b1; in_TOP_ARLEN = 8'd0;
        repeat (2) tick();
        #1;
        n_checks++;
        if ({out_BUS_ARVALID, out_TOP_ARREADY, out_BUS_RREADY} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 000", {out_BUS_ARVALID, out_TOP_ARREADY, out_BUS_RREADY});
        end
        reset = 1'b0; in_TOP_ARVALID = 1'b0;
        tick(); #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0 || out_TOP_RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: free=%0d out=%0d rvalid=%b, expected 16 0 0", dut.r_free_cnt, dut.r_out_cnt, out_TOP_RVALID);
        end
    endtask

    task automatic test_single_burst();
        tick();
        in_TOP_ARADDR = 32'h0000_1000; in_TOP_ARLEN = 8'd3; in_TOP_ARVALID = 1'b1; in_BUS_ARREADY = 1'b1;
        #1;
        n_checks++;
        if ({out_BUS_ARVALID, out_TOP_ARREADY} !== 2'b11 || out_BUS_ARADDR !== 32'h0000_1000 || out_BUS_ARLEN !== 8'd3) begin
            n_fail++;
            $display("FAIL single_ar: vld/rdy=%b addr=%h len=%0d, expected 11 00001000 3", {out_BUS_ARVALID, out_TOP_ARREADY}, out_BUS_ARADDR, out_BUS_ARLEN);
        end
        tick(); in_TOP_ARVALID = 1'b0; #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd12 || dut.r_out_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL single_credit: free=%0d out=%0d, expected 12 1", dut.r_free_cnt, dut.r_out_cnt);
        end
        tick(); drive_beat(1'b0); #1;
        n_checks++;
        if (out_TOP_RVALID !== 1'b0) begin
            n_fail++; $display("FAIL rvalid_early: got %b, expected 0", out_TOP_RVALID);
        end
        tick(); drive_beat(1'b0); #1;
        n_checks++;
        if (out_TOP_RVALID !== 1'b1) begin
            n_fail++; $display("FAIL rvalid_latency: got %b, expected 1", out_TOP_RVALID);
        end
        tick(); drive_beat(1'b0);
        tick(); drive_beat(1'b1);
        tick(); idle_bus(); in_TOP_RREADY = 1'b1;
        repeat (4) tick();
        in_TOP_RREADY = 1'b0; #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0 || sb.size() != 0 || out_TOP_RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: free=%0d out=%0d left=%0d rvalid=%b, expected 16 0 0 0", dut.r_free_cnt, dut.r_out_cnt, sb.size(), out_TOP_RVALID);
        end
    endtask

    task automatic test_credit_hold();
        logic bad;
        in_TOP_RREADY = 1'b0;
        tick(); in_TOP_ARADDR = 32'h2000; in_TOP_ARLEN = 8'd15; in_TOP_ARVALID = 1'b1; #1;
        n_checks++;
        if (out_BUS_ARVALID !== 1'b1) begin
            n_fail++; $display("FAIL credit_first: got %b, expected 1", out_BUS_ARVALID);
        end
        tick(); in_TOP_ARADDR = 32'h3000; #1;
        n_checks++;
        if ({out_BUS_ARVALID, out_TOP_ARREADY} !== 2'b00) begin
            n_fail++; $display("FAIL credit_second_held: got %b, expected 00", {out_BUS_ARVALID, out_TOP_ARREADY});
        end
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_beat(i == 15); #1;
            if (out_BUS_ARVALID !== 1'b0) bad = 1'b1;
            tick();
        end
        idle_bus(); in_TOP_RREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (out_BUS_ARVALID !== 1'b0) bad = 1'b1;
            tick();
        end
        #1;
        n_checks++;
        if (bad !== 1'b0 || out_BUS_ARVALID !== 1'b1 || dut.r_free_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL credit_release: early=%b arvalid=%b free=%0d, expected 0 1 16", bad, out_BUS_ARVALID, dut.r_free_cnt);
        end
        tick(); in_TOP_ARVALID = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_beat(i == 15); #1;
            if (i > 0 && out_TOP_RVALID !== 1'b1) bad = 1'b1;
            tick();
        end
        idle_bus(); tick(); #1;
        n_checks++;
        if (bad !== 1'b0 || sb.size() != 0 || dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL credit_stream: gap=%b left=%0d free=%0d out=%0d, expected 0 0 16 0", bad, sb.size(), dut.r_free_cnt, dut.r_out_cnt);
        end
    endtask

    task automatic test_maxreqs();
        logic bad;
        in_TOP_RREADY = 1'b1; idle_bus();
        tick(); in_TOP_ARLEN = 8'd0; in_TOP_ARVALID = 1'b1; in_BUS_ARREADY = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_BUS_ARVALID !== 1'b1) bad = 1'b1;
            tick();
        end
        #1;
        n_checks++;
        if (bad !== 1'b0 || out_BUS_ARVALID !== 1'b0 || dut.r_out_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL maxreqs_hold: miss=%b arvalid=%b out=%0d, expected 0 0 4", bad, out_BUS_ARVALID, dut.r_out_cnt);
        end
        drive_beat(1'b1);
        tick(); idle_bus(); #1;
        n_checks++;
        if (out_BUS_ARVALID !== 1'b1) begin
            n_fail++; $display("FAIL maxreqs_release: got %b, expected 1", out_BUS_ARVALID);
        end
        tick(); in_TOP_ARVALID = 1'b0; #1;
        n_checks++;
        if (dut.r_out_cnt !== 3'd4) begin
            n_fail++; $display("FAIL maxreqs_count: got %0d, expected 4", dut.r_out_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive_beat(1'b1); tick();
        end
        idle_bus(); repeat (2) tick(); #1;
        n_checks++;
        if (sb.size() != 0 || dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL maxreqs_drain: left=%0d free=%0d out=%0d, expected 0 16 0", sb.size(), dut.r_free_cnt, dut.r_out_cnt);
        end
    endtask

    task automatic test_exact_credit();
        in_TOP_RREADY = 1'b0;
        tick(); in_TOP_ARLEN = 8'd11; in_TOP_ARVALID = 1'b1;
        tick(); in_TOP_ARVALID = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_beat(i == 11); tick();
        end
        idle_bus(); #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd4) begin
            n_fail++; $display("FAIL exact_setup: free=%0d, expected 4", dut.r_free_cnt);
        end
        in_TOP_ARLEN = 8'd4; in_TOP_ARVALID = 1'b1; in_TOP_RREADY = 1'b1; #1;
        n_checks++;
        if (out_BUS_ARVALID !== 1'b0) begin
            n_fail++; $display("FAIL exact_same_cycle: got %b, expected 0", out_BUS_ARVALID);
        end
        tick(); in_TOP_RREADY = 1'b0; #1;
        n_checks++;
        if (out_BUS_ARVALID !== 1'b1 || dut.r_free_cnt !== 5'd5) begin
            n_fail++; $display("FAIL exact_next_cycle: arvalid=%b free=%0d, expected 1 5", out_BUS_ARVALID, dut.r_free_cnt);
        end
        tick(); in_TOP_ARVALID = 1'b0; #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd0) begin
            n_fail++; $display("FAIL exact_reserve: free=%0d, expected 0", dut.r_free_cnt);
        end
        in_TOP_RREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(i == 4); tick();
        end
        idle_bus(); repeat (12) tick(); #1;
        n_checks++;
        if (sb.size() != 0 || dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL exact_drain: left=%0d free=%0d out=%0d, expected 0 16 0", sb.size(), dut.r_free_cnt, dut.r_out_cnt);
        end
    endtask

    task automatic test_clk_en();
        logic bad;
        in_TOP_RREADY = 1'b0;
        tick(); in_TOP_ARLEN = 8'd1; in_TOP_ARVALID = 1'b1;
        tick(); in_TOP_ARVALID = 1'b0; drive_beat(1'b0);
        tick(); idle_bus();
        clk_en = 1'b0; in_TOP_ARVALID = 1'b1; in_BUS_ARREADY = 1'b1; in_TOP_RREADY = 1'b1;
        drive_beat(1'b1);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({out_BUS_ARVALID, out_TOP_ARREADY, out_BUS_RREADY} !== 3'b000) bad = 1'b1;
            tick();
        end
        #1;
        n_checks++;
        if (bad !== 1'b0 || dut.r_free_cnt !== 5'd14 || dut.r_out_cnt !== 3'd1 || out_TOP_RVALID !== 1'b1 || sb.size() != 1) begin
            n_fail++;
            $display("FAIL clk_en_freeze: hs=%b free=%0d out=%0d rvalid=%b held=%0d, expected 0 14 1 1 1", bad, dut.r_free_cnt, dut.r_out_cnt, out_TOP_RVALID, sb.size());
        end
        in_TOP_ARVALID = 1'b0; clk_en = 1'b1;
        tick(); idle_bus(); repeat (2) tick(); #1;
        n_checks++;
        if (sb.size() != 0 || dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL clk_en_resume: left=%0d free=%0d out=%0d, expected 0 16 0", sb.size(), dut.r_free_cnt, dut.r_out_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        in_TOP_RREADY = 1'b0;
        tick(); in_TOP_ARLEN = 8'd7; in_TOP_ARVALID = 1'b1;
        tick(); in_TOP_ARVALID = 1'b0; drive_beat(1'b0);
        tick(); drive_beat(1'b0);
        tick(); idle_bus(); reset = 1'b1;
        tick(); #1;
        n_checks++;
        if (dut.r_free_cnt !== 5'd16 || dut.r_out_cnt !== 3'd0 || out_TOP_RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: free=%0d out=%0d rvalid=%b, expected 16 0 0", dut.r_free_cnt, dut.r_out_cnt, out_TOP_RVALID);
        end
        reset = 1'b0;
        tick(); in_TOP_ARLEN = 8'd15; in_TOP_ARVALID = 1'b1; #1;
        n_checks++;
        if (out_BUS_ARVALID !== 1'b1) begin
            n_fail++; $display("FAIL reset_credit_restored: got %b, expected 1", out_BUS_ARVALID);
        end
        in_TOP_ARVALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_credit_hold();
        test_maxreqs();
        test_exact_credit();
        test_clk_en();
        test_reset_mid_burst();
        tick(); tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty: left=%0d, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
